// File: rtl/jtag_shift_seq.sv
// jtag_shift_seq: command sequencer that drives one jtag_shift transfer.
// It takes an IR8 or DR16 command on a valid/ready port. It then generates
// the latch / reset-edge / run-clock protocol on the sh_* pins. The captured
// word comes back on a valid/ready response port.
// sh_clk is a registered, divided copy of clk: HALF_DIV clk cycles per half.
// Build option: define JTAG_SEQ_TIMEOUT_EN to give up after MAX_EDGES run
// edges without done. The response then reports rsp_err=1 and rsp_data=0.
module jtag_shift_seq #(
  parameter int unsigned HALF_DIV  = 4,
  parameter int unsigned MAX_EDGES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] sh_data,
  output logic        sh_mode,
  output logic        sh_reset,
  output logic        sh_enable,
  output logic        sh_clk,
  input  logic        sh_done,
  input  logic [15:0] sh_data_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    RST_HI = 3'd2,
    RUN_LO = 3'd3,
    RUN_HI = 3'd4,
    RESP   = 3'd5
  } state_e;

  // Phase counter counts down; the last cycle of a timed state is phase 0.
  localparam logic [7:0] PHASE_LOAD = 8'(HALF_DIV - 1);
  // The edge counter saturates here; with the timeout enabled it is also the limit.
  localparam logic [7:0] EDGE_LIMIT = 8'(MAX_EDGES);

  state_e      state_q,     state_d;
  logic [7:0]  phase_q,     phase_d;
  logic [7:0]  edge_q,      edge_d;
  logic [15:0] sh_data_q,   sh_data_d;
  logic        sh_mode_q,   sh_mode_d;
  logic        sh_reset_q,  sh_reset_d;
  logic        sh_enable_q, sh_enable_d;
  logic        sh_clk_q,    sh_clk_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q,  rsp_data_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        phase_last;

  assign phase_last = (phase_q == 8'd0);

  // Next-state and registered-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    edge_d      = edge_q;
    sh_data_d   = sh_data_q;
    sh_mode_d   = sh_mode_q;
    sh_reset_d  = sh_reset_q;
    sh_enable_d = sh_enable_q;
    sh_clk_d    = sh_clk_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          sh_data_d   = cmd_data;
          sh_mode_d   = cmd_mode;
          sh_reset_d  = 1'b1;
          sh_enable_d = 1'b1;
          sh_clk_d    = 1'b0;
          phase_d     = PHASE_LOAD;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        phase_d = phase_q - 8'd1;
        if (phase_last) begin
          // Reset edge: clock rises while jtag_shift reset is still asserted.
          sh_clk_d = 1'b1;
          phase_d  = PHASE_LOAD;
          state_d  = RST_HI;
        end
      end
      RST_HI: begin
        phase_d = phase_q - 8'd1;
        if (phase_last) begin
          sh_clk_d   = 1'b0;
          sh_reset_d = 1'b0;
          phase_d    = PHASE_LOAD;
          state_d    = RUN_LO;
        end
      end
      RUN_LO: begin
        phase_d = phase_q - 8'd1;
        if (phase_last) begin
          sh_clk_d = 1'b1;
          edge_d   = (edge_q == EDGE_LIMIT) ? edge_q : edge_q + 8'd1;
          phase_d  = PHASE_LOAD;
          state_d  = RUN_HI;
        end
      end
      RUN_HI: begin
        phase_d = phase_q - 8'd1;
        if (phase_last) begin
          phase_d = PHASE_LOAD;
          if (sh_done) begin
            // Done on the final allowed edge still counts as success.
            sh_clk_d    = 1'b0;
            sh_enable_d = 1'b0;
            sh_reset_d  = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = sh_data_out;
            rsp_err_d   = 1'b0;
            state_d     = RESP;
`ifdef JTAG_SEQ_TIMEOUT_EN
          end else if (edge_q >= EDGE_LIMIT) begin
            sh_clk_d    = 1'b0;
            sh_enable_d = 1'b0;
            sh_reset_d  = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 16'h0000;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
`endif
          end else begin
            sh_clk_d = 1'b0;
            state_d  = RUN_LO;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          edge_d      = 8'd0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; async reset forces every pin to a safe idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= PHASE_LOAD;
      edge_q      <= 8'd0;
      sh_data_q   <= 16'h0000;
      sh_mode_q   <= 1'b0;
      sh_reset_q  <= 1'b0;
      sh_enable_q <= 1'b0;
      sh_clk_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      edge_q      <= edge_d;
      sh_data_q   <= sh_data_d;
      sh_mode_q   <= sh_mode_d;
      sh_reset_q  <= sh_reset_d;
      sh_enable_q <= sh_enable_d;
      sh_clk_q    <= sh_clk_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sh_data   = sh_data_q;
  assign sh_mode   = sh_mode_q;
  assign sh_reset  = sh_reset_q;
  assign sh_enable = sh_enable_q;
  assign sh_clk    = sh_clk_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
